// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
// Master issues start with operands; slave returns busy/done and flags.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first,
// parallel result with carry and signed-overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s;
  logic             c_nx;
  logic             last;
  logic             load;
  logic [WIDTH-1:0] res_nx;

  assign s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nx   = (a_sr[0] & b_sr[0])
                | (a_sr[0] & carry)
                | (b_sr[0] & carry);
  assign last   = (state == RUN) && (cnt == LAST);
  assign load   = (state != RUN) && bus.start;
  assign res_nx = {s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN:  if (last) state_nx = FIN;
      FIN:  state_nx = bus.start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      RUN:     bus.busy = 1'b1;
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

  // Subtract is A + ~B + 1: invert B at load and seed carry with mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.mode ? ~bus.b : bus.b;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= bus.mode;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nx;
      carry  <= c_nx;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum_q  <= res_nx;
        cout_q <= c_nx;
        ovf_q  <= carry ^ c_nx;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor with a start/done handshake. Operands are captured in parallel, processed LSB-first one bit per clock through a single full-adder slice, and the result is presented in parallel with carry and signed-overflow flags. It is the generalised successor of the team's fixed 8-bit serial adder. It adds a width parameter, a subtract mode, explicit busy/done handshaking and status flags, and sits between a register-file style operand source and a result consumer.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled on a rising edge of Clock.
- Mode  input  1  0 = A+B, 1 = A-B; captured with Start.
- A  input  WIDTH  operand A; captured with Start.
- B  input  WIDTH  operand B; captured with Start.
- Busy  output  1  high while bits are being processed.
- Done  output  1  one-cycle pulse when the result is valid.
- Sum  output  WIDTH  registered result; holds until the next completion.
- CarryOut  output  1  carry out of the MSB; in subtract mode 1 means no borrow (A >= B unsigned).
- Overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
- States:
  - IDLE: Busy=0, Done=0.
  - RUN: Busy=1.
  - FIN: Done=1, Busy=0.
- IDLE or FIN with Start=1 at an edge:
  - Load a_sr<=A, b_sr<=(Mode ? ~B : B), carry<=Mode, bit counter<=0.
  - Go to RUN.
- FIN with Start=0: go to IDLE.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - Shift s into the MSB of the internal result shift register; shift a_sr and b_sr right.
  - carry <= majority(a_sr[0], b_sr[0], carry); counter += 1.
  - Record the carry into the MSB at the edge where counter = WIDTH-1.
- RUN, at the edge processing bit WIDTH-1:
  - Sum <= final shifted result.
  - CarryOut <= final carry.
  - Overflow <= carry_into_msb ^ final carry.
  - Go to FIN.
- Start while in RUN is ignored; operands and Mode are not re-sampled.
- Width rules:
  - Counter width is $clog2(WIDTH).
  - Sum wraps modulo 2^WIDTH.
  - In subtract mode, B is inverted and carry-in is 1 (two's complement).
- Reset asserted (any state, including mid-RUN), immediately and asynchronously:
  - state=IDLE, Busy=0, Done=0, Sum=0, CarryOut=0, Overflow=0, internal registers cleared.
  - An aborted operation produces no Done and does not alter Sum beyond clearing it.
- Reset deasserted: the first edge may accept Start.

## Timing
- Start sampled at edge E0. Busy is high from after E0 through the cycle following E(WIDTH-1).
- Sum, CarryOut and Overflow update at edge E(WIDTH). Done is high for exactly the one cycle between E(WIDTH) and E(WIDTH+1).
- Latency is WIDTH+1 edges from the Start edge to the Done-visible result.
- Throughput is one operation per WIDTH+1 cycles when Start is held high; back-to-back Start is accepted in FIN.
- Flags and Sum are stable for every cycle except at the completion edge.
- During RUN, outputs keep the previous result.

## Test plan
- Reset=1 for 5 cycles, then 0: all outputs 0, Busy=0; Start on the first edge is accepted.
- WIDTH=8, add 0x00+0x00, 0x00+0xFF, 0xB7+0x0D, 0x01+0x80:
  - Sum = 0x00, 0xFF, 0xC4, 0x81; CarryOut=0 and Overflow=0 in all cases.
  - Done pulses exactly 9 edges after each Start edge.
- Add boundaries: 0x7F+0x01 -> Sum 0x80, C=0, V=1; 0xFF+0x01 -> Sum 0x00, C=1, V=0.
- Subtract:
  - 0x42-0x21 -> 0x21, C=1, V=0.
  - 0x00-0x01 -> 0xFF, C=0, V=0.
  - 0x80-0x01 -> 0x7F, C=1, V=1.
- Start pulsed again mid-RUN with different A and B: ignored, and the original result is reported. Start held high continuously: back-to-back operations with a Done pulse every 9 cycles.
- Reset asserted at bit 4 of 0x42+0x21 after a prior result of 0xC4:
  - Outputs go 0 asynchronously and no Done occurs.
  - A new Start after release gives the correct result.
- Repeat with WIDTH=16 and WIDTH=2:
  - 16: 0xFFFF+0x0001 -> 0x0000, C=1.
  - 2: 2'b01-2'b10 -> 2'b11, C=0, V=1.
  - Latency is WIDTH+1 in both cases.
